// File: rtl/btb_pred.sv
// Set-associative branch target buffer: tree pseudo-LRU, 1-cycle registered lookup, set-walking flush.
// Define BTB_PRED_COUNTER_EN to add 2-bit direction counters; otherwise a not-taken hit-update invalidates.
module btb_pred #(
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              flush,
    output logic              busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int PL_W  = WAYS - 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    // A tree bit of 0 points the victim search at its lower-numbered half.
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [2:0] t;
        logic       lo;
        t  = 3'(bits);
        lo = (32'(way) < 32'd2);
        if (WAYS == 2) begin
            t[0] = (way == WAY_W'(0));
        end else begin
            t[0] = lo;
            t[1] = lo ? (way == WAY_W'(0)) : t[1];
            t[2] = lo ? t[2] : (way == WAY_W'(2));
        end
        return t[PL_W-1:0];
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(bits);
        if (WAYS == 2) begin
            v = {1'b0, t[0]};
        end else begin
            v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        end
        return v[WAY_W-1:0];
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        if (taken) begin
            n = (c == 2'd3) ? c : c + 2'd1;
        end else begin
            n = (c == 2'd0) ? c : c - 2'd1;
        end
        return n;
    endfunction

    state_t            r_state;
    logic [IDX_W-1:0]  r_fl_idx;
    logic              r_busy;
    logic              r_hit;
    logic              r_pred_taken;
    logic [ADDR_W-1:0] r_pred_target;

    logic [WAYS-1:0]   r_valid  [SETS];
    logic [PL_W-1:0]   r_plru   [SETS];
    logic [TAG_W-1:0]  r_tag    [SETS][WAYS];
    logic [ADDR_W-1:0] r_target [SETS][WAYS];
`ifdef BTB_PRED_COUNTER_EN
    logic [1:0]        r_ctr    [SETS][WAYS];
`endif

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_idle;
    logic              w_lk_do;
    logic              w_up_do;
    logic              w_lk_hit;
    logic [WAY_W-1:0]  w_lk_way;
    logic              w_up_hit;
    logic [WAY_W-1:0]  w_up_way;
    logic              w_inv_any;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_up_sel;
    logic              w_lk_touch;
    logic              w_lk_taken;
    logic              w_up_wr;
    logic              w_up_kill;
    logic [PL_W-1:0]   w_lk_plru;
    logic [PL_W-1:0]   w_plru_base;
    logic [PL_W-1:0]   w_up_plru;
    logic              w_unused;

    assign w_lk_idx = lookup_pc[IDX_W:1];
    assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
    assign w_up_idx = upd_pc[IDX_W:1];
    assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+1];
    assign w_unused = &{1'b0, lookup_pc[0], upd_pc[0]};

    assign w_idle  = (r_state == ST_IDLE);
    assign w_lk_do = lookup_valid && w_idle;
    assign w_up_do = upd_valid && w_idle;

    // Lookup tag match; the lowest matching way wins.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_way = WAY_W'(w);
            end else begin
                w_lk_hit = w_lk_hit;
            end
        end
    end

    // Update tag match plus lowest-numbered invalid way in the update set.
    always_comb begin
        w_up_hit  = 1'b0;
        w_up_way  = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_hit = 1'b1;
                w_up_way = WAY_W'(w);
            end else begin
                w_up_hit = w_up_hit;
            end
            if (!r_valid[w_up_idx][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_W'(w);
            end else begin
                w_inv_any = w_inv_any;
            end
        end
    end

    assign w_up_sel   = w_up_hit ? w_up_way :
                        (w_inv_any ? w_inv_way : plru_victim(r_plru[w_up_idx]));
    assign w_lk_touch = w_lk_do && w_lk_hit;
    assign w_lk_plru  = plru_touch(r_plru[w_lk_idx], w_lk_way);
    // Same-set lookup and update: apply the lookup touch first so the update's touch lands last.
    assign w_plru_base = (w_lk_touch && (w_lk_idx == w_up_idx)) ? w_lk_plru : r_plru[w_up_idx];
    assign w_up_plru   = plru_touch(w_plru_base, w_up_sel);

`ifdef BTB_PRED_COUNTER_EN
    assign w_lk_taken = r_ctr[w_lk_idx][w_lk_way][1];
    assign w_up_wr    = w_up_do && (w_up_hit || upd_taken);
    assign w_up_kill  = 1'b0;
`else
    assign w_lk_taken = 1'b1;
    assign w_up_wr    = w_up_do && upd_taken;
    assign w_up_kill  = w_up_do && w_up_hit && !upd_taken;
`endif

    // Control state, valid/PLRU bits and registered lookup outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_fl_idx      <= '0;
            r_hit         <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_hit         <= w_lk_touch;
            r_pred_taken  <= w_lk_touch && w_lk_taken;
            r_pred_target <= w_lk_touch ? r_target[w_lk_idx][w_lk_way] : '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_lk_touch) r_plru[w_lk_idx] <= w_lk_plru;
                    if (w_up_wr) begin
                        r_valid[w_up_idx][w_up_sel] <= 1'b1;
                        r_plru[w_up_idx]            <= w_up_plru;
                    end
                    if (w_up_kill) r_valid[w_up_idx][w_up_way] <= 1'b0;
                    if (flush) begin
                        r_state  <= ST_FLUSH;
                        r_busy   <= 1'b1;
                        r_fl_idx <= '0;
                    end
                end
                ST_FLUSH: begin
                    r_valid[r_fl_idx] <= '0;
                    r_plru[r_fl_idx]  <= '0;
                    if (r_fl_idx == IDX_W'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_fl_idx <= r_fl_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Entry payload; only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_up_wr) begin
            r_tag[w_up_idx][w_up_sel]    <= w_up_tag;
            r_target[w_up_idx][w_up_sel] <= upd_target;
`ifdef BTB_PRED_COUNTER_EN
            r_ctr[w_up_idx][w_up_sel]    <= w_up_hit ? ctr_next(r_ctr[w_up_idx][w_up_way], upd_taken)
                                                     : 2'd2;
`endif
        end
    end

    assign hit         = r_hit;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;
    assign busy        = r_busy;

endmodule
